// File: rtl/sticky_event_bank.sv
// sticky_event_bank: synchronized sticky event flags with first-event capture and a
// saturating accepted-edge counter. Optional input debounce: define DEBOUNCE_EN.
module sticky_event_bank #(
   parameter  int N_CH            = 4,
   parameter  int CNT_W           = 8,
   parameter  int DEBOUNCE_CYCLES = 4,
   localparam int IDX_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  btn,
   input  logic [N_CH-1:0]  clr,
   input  logic             clr_cnt,
   output logic [N_CH-1:0]  out,
   output logic             any,
   output logic             first_valid,
   output logic [IDX_W-1:0] first_idx,
   output logic [CNT_W-1:0] count
);

   logic [N_CH-1:0]  s1, s2;
   logic [N_CH-1:0]  level;
   logic [N_CH-1:0]  hist;
   logic [N_CH-1:0]  edge_acc;
   logic [N_CH-1:0]  out_n;
   logic             fv_n;
   logic [IDX_W-1:0] idx_n;
   logic [IDX_W-1:0] low_idx;
   logic             low_found;
   logic [5:0]       pop;
   logic [CNT_W+5:0] sum;
   logic [CNT_W-1:0] count_n;

`ifdef DEBOUNCE_EN
   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0] stable;
   logic [15:0]     db_cnt [N_CH];

   // stable follows s2 only after it has disagreed for DEBOUNCE_CYCLES consecutive samples
   always_ff @(posedge clk) begin
      if (rst) begin
         stable <= '0;
         for (int unsigned i = 0; i < N_CH; i++) db_cnt[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < N_CH; i++) begin
            if (s2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   assign level = stable;
`else
   logic unused_debounce_cycles;
   assign unused_debounce_cycles = (DEBOUNCE_CYCLES > 0);
   assign level = s2;
`endif

   assign edge_acc = level & ~hist;

   always_comb begin
      low_idx   = '0;
      low_found = 1'b0;
      pop       = '0;
      for (int unsigned i = 0; i < N_CH; i++) begin
         pop = pop + 6'(edge_acc[i]);
         if (edge_acc[i] && !low_found) begin
            low_found = 1'b1;
            low_idx   = IDX_W'(i);
         end
      end
   end

   // set has priority over clear on the same channel
   assign out_n = (out & ~clr) | edge_acc;

   always_comb begin
      fv_n  = first_valid;
      idx_n = first_idx;
      if (!first_valid || clr[first_idx]) begin
         fv_n = low_found;
         if (low_found) idx_n = low_idx;
      end
   end

   // clr_cnt reloads with this cycle's edges so none are dropped
   always_comb begin
      sum = (clr_cnt ? '0 : {6'b0, count}) + {{CNT_W{1'b0}}, pop};
      if (|sum[CNT_W+5:CNT_W]) count_n = '1;
      else                     count_n = sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1          <= '0;
         s2          <= '0;
         hist        <= '0;
         out         <= '0;
         any         <= 1'b0;
         first_valid <= 1'b0;
         first_idx   <= '0;
         count       <= '0;
      end else begin
         s1          <= btn;
         s2          <= s1;
         hist        <= level;
         out         <= out_n;
         any         <= |out_n;
         first_valid <= fv_n;
         first_idx   <= idx_n;
         count       <= count_n;
      end
   end

endmodule

// File: tb/tb_sticky_event_bank.sv
// tb_sticky_event_bank: directed stimulus with expected snapshots queued per target
// cycle; a negedge monitor pops and compares them. Honours DEBOUNCE_EN for latency.
module tb_sticky_event_bank;

`ifdef DEBOUNCE_EN
   localparam int LAT = 3 + 4;
   localparam int H   = 5;
`else
   localparam int LAT = 3;
   localparam int H   = 1;
`endif

   logic       clk;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] clr;
   logic       clr_cnt;
   logic [3:0] out;
   logic       any;
   logic       first_valid;
   logic [1:0] first_idx;
   logic [7:0] count;

   sticky_event_bank #(.N_CH(4), .CNT_W(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .btn         (btn),
      .clr         (clr),
      .clr_cnt     (clr_cnt),
      .out         (out),
      .any         (any),
      .first_valid (first_valid),
      .first_idx   (first_idx),
      .count       (count)
   );

   typedef struct {
      int         cyc;
      string      name;
      logic [3:0] o;
      logic       a;
      logic       fv;
      logic [1:0] idx;
      logic [7:0] c;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            checks++;
            if ({out, any, first_valid, first_idx, count} !==
                {sb[i].o, sb[i].a, sb[i].fv, sb[i].idx, sb[i].c}) begin
               errors++;
               $display("FAIL %s cyc=%0d got out=%b any=%b fv=%b idx=%0d count=%0d required out=%b any=%b fv=%b idx=%0d count=%0d",
                        sb[i].name, cyc, out, any, first_valid, first_idx, count,
                        sb[i].o, sb[i].a, sb[i].fv, sb[i].idx, sb[i].c);
            end
            sb.delete(i);
         end
      end
   end

   task automatic push_exp(input int dc, input string nm, input logic [3:0] o, input logic a,
                           input logic fv, input logic [1:0] idx, input logic [7:0] c);
      exp_t e;
      e.cyc = cyc + dc; e.name = nm; e.o = o; e.a = a; e.fv = fv; e.idx = idx; e.c = c;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) tick();
   endtask

   initial begin
      rst = 1'b1; btn = 4'b0010; clr = '0; clr_cnt = 1'b0;
      push_exp(2, "reset", 4'b0000, 0, 0, 0, 0);
      wait_cyc(2);

      // btn held through reset release is a fresh rising edge
      rst = 1'b0;
      push_exp(LAT - 1, "pre_latency", 4'b0000, 0, 0, 0, 0);
      push_exp(LAT, "first_set", 4'b0010, 1, 1, 1, 1);
      wait_cyc(LAT);
      btn = 4'b0000;
      push_exp(LAT + 1, "fall_hold", 4'b0010, 1, 1, 1, 1);
      wait_cyc(LAT + 1);

      rst = 1'b1;
      push_exp(1, "reset2", 4'b0000, 0, 0, 0, 0);
      tick();
      rst = 1'b0; btn = 4'b1010;
      push_exp(LAT, "pair", 4'b1010, 1, 1, 1, 2);
      wait_cyc(LAT);

      clr = 4'b0010;
      push_exp(1, "clr_release", 4'b1000, 1, 0, 1, 2);
      tick();
      clr = '0;

      btn = 4'b1011;
      push_exp(LAT, "recapture", 4'b1001, 1, 1, 0, 3);
      wait_cyc(LAT);

      btn = 4'b1111;
      wait_cyc(LAT - 1);
      clr = 4'b0100;
      push_exp(1, "set_wins", 4'b1101, 1, 1, 0, 4);
      tick();
      clr = '0;

      btn = 4'b0000;
      push_exp(LAT + 2, "fall_ignored", 4'b1101, 1, 1, 0, 4);
      wait_cyc(LAT + 2);

      btn = 4'b0010;
      wait_cyc(LAT - 1);
      clr = 4'b0001;
      push_exp(1, "release_recap", 4'b1110, 1, 1, 1, 5);
      tick();
      clr = '0;

      clr = 4'b0011;
      push_exp(1, "clr_noedge", 4'b1100, 1, 0, 1, 5);
      tick();
      clr = '0;

      clr_cnt = 1'b1;
      push_exp(1, "clr_cnt", 4'b1100, 1, 0, 1, 0);
      tick();
      clr_cnt = 1'b0;

      for (int r = 0; r < 254; r++) begin
         btn[0] = 1'b1; wait_cyc(H);
         btn[0] = 1'b0; wait_cyc(H);
      end
      push_exp(LAT, "cnt_254", 4'b1101, 1, 1, 0, 254);
      wait_cyc(LAT);
      for (int r = 0; r < 46; r++) begin
         btn[0] = 1'b1; wait_cyc(H);
         btn[0] = 1'b0; wait_cyc(H);
      end
      push_exp(LAT, "cnt_sat", 4'b1101, 1, 1, 0, 255);
      wait_cyc(LAT);

      btn[0] = 1'b1;
      wait_cyc(LAT - 1);
      clr_cnt = 1'b1;
      push_exp(1, "clr_cnt_edge", 4'b1101, 1, 1, 0, 1);
      tick();
      clr_cnt = 1'b0;

      // edges arriving in the reset cycle are discarded, then re-seen after release
      btn = 4'b1111;
      wait_cyc(LAT - 1);
      rst = 1'b1;
      push_exp(1, "rst_prio", 4'b0000, 0, 0, 0, 0);
      tick();
      rst = 1'b0;
      push_exp(LAT - 1, "rst_fill", 4'b0000, 0, 0, 0, 0);
      push_exp(LAT, "rst_release", 4'b1111, 1, 1, 0, 4);
      wait_cyc(LAT);

`ifdef DEBOUNCE_EN
      btn = 4'b1110;
      wait_cyc(LAT + 2);
      clr = 4'b0001;
      push_exp(1, "db_clr", 4'b1110, 1, 0, 0, 4);
      tick();
      clr = '0;
      push_exp(LAT + 6, "db_short", 4'b1110, 1, 0, 0, 4);
      btn = 4'b1111; wait_cyc(3);
      btn = 4'b1110; wait_cyc(LAT + 3);
      push_exp(LAT + 6, "db_long", 4'b1111, 1, 1, 0, 5);
      btn = 4'b1111; wait_cyc(5);
      btn = 4'b1110; wait_cyc(LAT + 1);
`endif

      wait_cyc(2);
      if (sb.size() != 0) begin
         checks += sb.size();
         errors += sb.size();
         $display("FAIL unchecked_entries got %0d pending required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sticky_event_bank.md
STICKY_EVENT_BANK -- requirements
Module: sticky_event_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent button/event channels (1..32).
REQ-002 Parameter CNT_W, default 8, width of the saturating event counter.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4, required stable cycles before an input change is accepted (1..65535); used only when DEBOUNCE_EN is defined.
REQ-004 Derived IDX_W = max(1, clog2(N_CH)); SHALL NOT be overridden.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 btn  input  N_CH  asynchronous raw button/event levels, one bit per channel.
REQ-008 clr  input  N_CH  per-channel sticky-flag clear, sampled at clk edge.
REQ-009 clr_cnt  input  1  clears the event counter, sampled at clk edge.
REQ-010 out  output  N_CH  registered sticky flags, one per channel.
REQ-011 any  output  1  registered OR of all out bits.
REQ-012 first_valid  output  1  registered; first_idx holds a captured channel.
REQ-013 first_idx  output  IDX_W  registered index of the first channel to fire since last release.
REQ-014 count  output  CNT_W  registered saturating count of accepted rising edges.

Function
REQ-015 Each btn bit SHALL pass a 2-flop synchronizer (s1, s2) before any other use.
REQ-016 Without debounce, an accepted rising edge on channel i SHALL be s2[i]=1 while the previous s2 sample was 0.
REQ-017 With btn held high, out[i] SHALL assert at the 3rd rising clk edge after btn[i] rises (3 + DEBOUNCE_CYCLES with DEBOUNCE_EN).
REQ-018 out[i] SHALL stay 1 after btn[i] falls; only clr[i] or rst clears it.
REQ-019 Simultaneous accepted edge and clr[i] in the same cycle: set wins, out[i] stays/becomes 1.
REQ-020 clr[i] with no edge: out[i] = 0 after that clk edge; clr on an already-clear channel has no effect.
REQ-021 any SHALL equal the OR of next-state out, updated on the same edge as out.
REQ-022 When first_valid = 0 and one or more edges are accepted, first_valid <= 1 and first_idx <= lowest-index channel with an accepted edge.
REQ-023 While first_valid = 1, further edges SHALL NOT change first_idx.
REQ-024 clr[first_idx] asserted releases the capture: first_valid <= 0, unless an edge is accepted that cycle, in which case the lowest-index edge is captured.
REQ-025 count SHALL add the popcount of accepted edges each cycle, saturating at 2^CNT_W-1 (no wrap).
REQ-026 clr_cnt SHALL load count with the popcount of edges accepted that cycle (edges are not lost).
REQ-027 Falling edges SHALL NOT affect any output.

Reset
REQ-028 On rst=1 at a clk edge: out=0, any=0, first_valid=0, first_idx=0, count=0; synchronizer, edge-history and debounce state cleared to 0.
REQ-029 rst SHALL take priority over every other input; edges present during the rst cycle are discarded.
REQ-030 A btn held high through rst release SHALL be accepted as a new rising edge once the synchronizer fills (3 cycles after release).

Configuration
REQ-031 Macro DEBOUNCE_EN defined: per-channel counter increments while s2[i] differs from the stable level; the stable level updates when the counter reaches DEBOUNCE_CYCLES; any match resets the counter; edges are detected on the stable level.
REQ-032 DEBOUNCE_EN defined: pulses shorter than DEBOUNCE_CYCLES cycles SHALL produce no edge.
REQ-033 DEBOUNCE_EN undefined: no debounce logic is synthesized; the DEBOUNCE_CYCLES parameter is ignored.

Verification (N_CH=4, CNT_W=8, DEBOUNCE_CYCLES=4)
REQ-034 Hold rst 2 cycles, btn=4'b0010 held -> out=4'b0010, any=1, first_idx=1, count=1 at edge 3 (7 with DEBOUNCE_EN); btn drop leaves out unchanged.
REQ-035 btn=4'b1010 rising together -> first_idx=1, count=2; then clr=4'b0010 -> out=4'b1000, first_valid=0.
REQ-036 clr[2]=1 in the same cycle as channel 2's accepted edge -> out[2]=1, count incremented.
REQ-037 300 single-channel toggles with CNT_W=8 -> count stops at 255; clr_cnt -> count=0.
REQ-038 DEBOUNCE_EN: 3-cycle btn[0] pulse -> no change; 5-cycle pulse -> out[0]=1.
REQ-039 rst asserted while out=4'b1111, count=9 -> all outputs 0 next edge.
